// File: rtl/channel_buf_pkg.sv
// Shared constants and helpers for the channel buffer family.
package channel_buf_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 4;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/channel_fifo_ptr.sv
// Wrapping pointer register; relies on DEPTH being a power of two for the wrap.
module channel_fifo_ptr
    import channel_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/channel_fifo.sv
// First-word-fall-through channel FIFO with count-derived status and sticky
// overflow/underflow error flags.
module channel_fifo
    import channel_buf_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int AFULL_THRESH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [clog2_cnt(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int CNT_W = clog2_cnt(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AFULL_THRESH));
    assign rd_data     = mem[rd_ptr];

    channel_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    channel_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en & ~rd_acc) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("channel_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("channel_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= CNT_W'(DEPTH))
                else $error("channel_fifo: count exceeds DEPTH");
        end
    end

endmodule

// File: tb/tb_channel_fifo.sv
// Self-checking bench for channel_fifo (WIDTH=8, DEPTH=4, AFULL_THRESH=3).
module tb_channel_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [2:0]       count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: a queue of live entries plus the two sticky flags.
    logic [WIDTH-1:0] q[$];
    bit               m_ov;
    bit               m_un;

    channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then settle 1 time unit past the edge.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic c, input logic rs);
        bit rd_ok, wr_ok;
        wr_en = w; wr_data = d; rd_en = r; clr_err = c; reset = rs;
        if (rs) begin
            q.delete();
            m_ov = 0;
            m_un = 0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (w && !wr_ok) m_ov = 1; else if (c) m_ov = 0;
            if (r && !rd_ok) m_un = 1; else if (c) m_un = 0;
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0; reset = 0;
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow); else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hA1 + 8'(i), 0, 0, 0);
            total_cnt++; if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); else pass_cnt++;
            total_cnt++; if (almost_full !== (i + 1 >= AFULL)) $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i + 1 >= AFULL)); else pass_cnt++;
            total_cnt++; if (full !== (i == 3)) $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 3)); else pass_cnt++;
            total_cnt++; if (rd_data !== 8'hA1) $display("FAIL fill_head[%0d] got %h want a1", i, rd_data); else pass_cnt++;
        end
    endtask

    task automatic test_full_rw_drain();
        logic [WIDTH-1:0] exp_seq [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        step(1, 8'hB5, 1, 0, 0);
        total_cnt++; if (count !== 3'd4) $display("FAIL fullrw_count got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL fullrw_overflow got %b want 0", overflow); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (rd_data !== exp_seq[i]) $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, exp_seq[i]); else pass_cnt++;
            step(0, 8'h00, 1, 0, 0);
        end
        total_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0, 0);
        step(1, 8'hC0, 0, 0, 0);
        total_cnt++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (rd_data !== 8'hA1 + 8'(i)) $display("FAIL ovf_data[%0d] got %h want %h", i, rd_data, 8'hA1 + 8'(i)); else pass_cnt++;
            step(0, 8'h00, 1, 0, 0);
        end
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else pass_cnt++;
        step(0, 8'h00, 0, 1, 0);
        total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else pass_cnt++;
        // Underflow event coinciding with clr_err must leave the flag set.
        step(0, 8'h00, 1, 1, 0);
        total_cnt++; if (underflow !== 1'b1) $display("FAIL clr_vs_err got %b want 1", underflow); else pass_cnt++;
        step(0, 8'h00, 0, 1, 0);
        total_cnt++; if (underflow !== 1'b0) $display("FAIL unf_clear got %b want 0", underflow); else pass_cnt++;
    endtask

    task automatic test_underflow();
        step(0, 8'h00, 1, 0, 0);
        total_cnt++; if (underflow !== 1'b1) $display("FAIL unf_flag got %b want 1", underflow); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL unf_count got %0d want 0", count); else pass_cnt++;
        step(1, 8'h5A, 1, 0, 0);
        total_cnt++; if (count !== 3'd1) $display("FAIL empty_rw_count got %0d want 1", count); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h5A) $display("FAIL empty_rw_data got %h want 5a", rd_data); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b1) $display("FAIL empty_rw_unf got %b want 1", underflow); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        step(1, 8'h77, 0, 0, 1);
        total_cnt++; if (count !== 3'd0) $display("FAIL rstmid_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL rstmid_empty got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (rd_data !== 8'h00) $display("FAIL rstmid_rd_data got %h want 00", rd_data); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL rstmid_unf got %b want 0", underflow); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 63) == 0));
            total_cnt++; if (count !== 3'(q.size())) $display("FAIL rnd_count[%0d] got %0d want %0d", n, count, q.size()); else pass_cnt++;
            total_cnt++; if ({full, empty, almost_full} !== {q.size() == DEPTH, q.size() == 0, q.size() >= AFULL})
                $display("FAIL rnd_status[%0d] got %b%b%b want %b%b%b", n, full, empty, almost_full,
                         q.size() == DEPTH, q.size() == 0, q.size() >= AFULL);
            else pass_cnt++;
            total_cnt++; if ({overflow, underflow} !== {m_ov, m_un}) $display("FAIL rnd_flags[%0d] got %b%b want %b%b", n, overflow, underflow, m_ov, m_un); else pass_cnt++;
            if (q.size() > 0) begin
                total_cnt++; if (rd_data !== q[0]) $display("FAIL rnd_head[%0d] got %h want %h", n, rd_data, q[0]); else pass_cnt++;
            end
        end
    endtask

    initial begin
        reset = 0; wr_en = 0; wr_data = '0; rd_en = 0; clr_err = 0;
        m_ov = 0; m_un = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_full_rw_drain();
        test_overflow();
        test_underflow();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/channel_fifo.md
Name: channel_fifo

Overview:
- Multi-entry successor to the single-entry channel buffer.
- Parametrised-depth, first-word-fall-through FIFO between a channel producer and a channel consumer.
- Provides full/empty/almost-full status, an occupancy count, and sticky overflow/underflow error flags with explicit clear.
- Drops into any channel path where a one-deep buffer stalls the producer.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AFULL_THRESH, 3, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request; pops the head entry.
- rd_data  output  WIDTH  head entry (first-word fall-through).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a read was rejected.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset (clk edge with reset=1):
  - wr_ptr, rd_ptr, count, overflow and underflow go to 0; all storage entries go to 0.
  - Resulting outputs: empty=1, full=0, almost_full=0, rd_data=0.
  - reset overrides all other inputs in the same cycle; any in-flight contents are discarded.
- Pointers:
  - log2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
  - full/empty are derived from count, not from pointer comparison.
- Write accept: wr_acc = wr_en & (~full | rd_acc).
  - On accept: mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en & ~empty.
  - On accept: rd_ptr increments.
- Count update: count <= count + wr_acc - rd_acc.
- rd_data = mem[rd_ptr] combinationally.
  - Valid only while empty=0.
  - When empty, it shows the stale entry at rd_ptr (0 after reset).
- Latency: a word written at edge N is visible on rd_data and poppable in cycle N+1 (one-cycle write-to-read).
- Boundary cases:
  - Full, wr_en & rd_en: both accepted, count stays DEPTH, no overflow.
  - Full, wr_en only: write dropped, storage and pointers unchanged, overflow <= 1.
  - Empty, rd_en: no pointer change, underflow <= 1.
  - Empty, wr_en & rd_en: write accepted, read rejected, underflow <= 1, count becomes 1. There is no bypass path.
- Error flags:
  - overflow and underflow stay set until clr_err or reset.
  - clr_err with a new error event in the same cycle: the error wins and the flag stays 1.
- Status outputs are registered-count-derived; they are combinational from count only, never from wr_en/rd_en.
- Assertions (simulation only):
  - DEPTH is a power of two and >= 2.
  - 1 <= AFULL_THRESH <= DEPTH.
  - count never exceeds DEPTH.

Decomposition:
- Package channel_buf_pkg holds:
  - default WIDTH/DEPTH constants;
  - the function clog2_cnt(DEPTH) for the count width.
- One sub-module: channel_fifo_ptr, a parametrised wrapping pointer register with reset, increment enable and a log2(DEPTH) output. It is instantiated twice (write and read).
- Storage, count and flags stay in channel_fifo.

Test Plan (WIDTH=8, DEPTH=4, AFULL_THRESH=3):
- Reset then idle 2 cycles -> empty=1, full=0, count=0, rd_data=8'h00, overflow=0, underflow=0.
- Write 8'hA1, A2, A3, A4 on consecutive cycles ->
  - count steps 1,2,3,4;
  - almost_full rises with count=3;
  - full=1 after the 4th write;
  - rd_data=8'hA1 from the cycle after the first write.
- While full, write 8'hB5 with rd_en=1 -> A1 popped, count stays 4. Then drain 4 reads -> rd_data sequence A2, A3, A4, B5, then empty=1 (wrap-around verified).
- While full, write 8'hC0 without read -> count stays 4, overflow=1, next reads return the original contents. Then pulse clr_err -> overflow=0.
- From empty, assert rd_en -> underflow=1, count=0. Next, wr_en and rd_en together with 8'h5A -> count=1, rd_data=8'h5A, underflow still 1.
- Fill with 3 entries, assert reset with wr_en=1 -> next cycle count=0, empty=1, rd_data=8'h00, no write taken.
